// File: rtl/tpu_reduce_acc_if.sv
// Handshake bundle between the TPU multiply array (master) and the reduce/accumulate
// block (slave). Both channels use valid/ready: a transfer happens on a rising clk edge
// where valid and ready are both high; once valid is raised, data and qualifiers stay
// stable until that transfer, and ready may be observed before valid is asserted.
interface tpu_reduce_acc_if #(
  parameter int ACC_W = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [255:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic [ACC_W-1:0] out_acc;
  logic             overflow;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_acc, overflow
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_acc, overflow
  );
endinterface

// File: rtl/tpu_reduce_acc.sv
// Sums 32 Float8 product lanes per beat into a signed fixed-point accumulator
// (LSB = 2^-9) across a burst, then packs the total back into one Float8.
module tpu_reduce_acc #(
  parameter int ACC_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  tpu_reduce_acc_if.slave        bus,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    S_ACC  = 2'd0,
    S_NORM = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [ACC_W-1:0] acc;
  logic             ovf_sticky;
  logic             out_valid_q;
  logic [7:0]       out_data_q;
  logic [ACC_W-1:0] out_acc_q;
  logic             overflow_q;

  logic signed [23:0] lane_sum;
  logic [17:0]        lane_mag;
  logic signed [23:0] lane_val;
  logic [ACC_W-1:0]   lane_ext;
  logic [ACC_W-1:0]   acc_sum;
  logic               add_ovf;

  logic [ACC_W-1:0]   pk_mag;
  int                 pk_p;
  int                 pk_be;
  logic [7:0]         pk_data;
  logic               pk_sat;

  // 24 bits covers 32 lanes of the largest product (32 * 480 * 512 < 2^23).
  always_comb begin
    lane_sum = '0;
    lane_mag = '0;
    lane_val = '0;
    for (int i = 0; i < 32; i++) begin
      lane_mag = '0;
      if (bus.in_data[8*i+3 +: 4] != 4'd0)
        lane_mag = {14'd0, 1'b1, bus.in_data[8*i +: 3]} << (bus.in_data[8*i+3 +: 4] - 4'd1);
      lane_val = {6'd0, lane_mag};
      if (bus.in_data[8*i+7])
        lane_val = -lane_val;
      lane_sum = lane_sum + lane_val;
    end
  end

  assign lane_ext = {{(ACC_W-24){lane_sum[23]}}, lane_sum};
  assign acc_sum  = acc + lane_ext;
  assign add_ovf  = (acc[ACC_W-1] == lane_ext[ACC_W-1]) && (acc_sum[ACC_W-1] != acc[ACC_W-1]);

  // Magnitude is taken unsigned so the most negative accumulator still packs as saturated.
  always_comb begin
    pk_mag  = acc[ACC_W-1] ? (~acc + 1'b1) : acc;
    pk_p    = -1;
    pk_be   = 0;
    pk_data = 8'h00;
    pk_sat  = 1'b0;
    for (int i = 0; i < ACC_W; i++)
      if (pk_mag[i]) pk_p = i;
    if (pk_p >= 3) begin
      pk_be = pk_p - 2;
      if (pk_be > 15) begin
        pk_data = {acc[ACC_W-1], 7'h7F};
        pk_sat  = 1'b1;
      end else begin
        pk_data = {acc[ACC_W-1], 4'(pk_be), 3'(pk_mag >> (pk_p - 3))};
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_ACC:   if (bus.in_valid && bus.in_last) state_nx = S_NORM;
      S_NORM:  state_nx = S_OUT;
      S_OUT:   if (bus.out_ready) state_nx = S_ACC;
      default: state_nx = S_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_ACC;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc         <= '0;
      ovf_sticky  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_acc_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      case (state)
        S_ACC: begin
          if (bus.in_valid) begin
            acc <= acc_sum;
            if (add_ovf) ovf_sticky <= 1'b1;
          end
        end
        S_NORM: begin
          out_data_q  <= pk_data;
          out_acc_q   <= acc;
          overflow_q  <= pk_sat | ovf_sticky;
          out_valid_q <= 1'b1;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            acc         <= '0;
            ovf_sticky  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_ACC);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_acc   = out_acc_q;
  assign bus.overflow  = overflow_q;
  assign dbg_state     = state;

endmodule
